div_uint16_uint8: RTL and testbench

Iterative fixed-latency unsigned divider: 16-bit dividend divided by 8-bit divisor, producing a 16-bit quotient and an 8-bit remainder. It is the inverse companion of the 8x8->16 pipelined multiplier black box, used in the Aetherling/Filament kernels wherever a product must be scaled back down, for example normalisation and averaging. Latency is fixed and independent of the operand values, so Filament timelines can schedule it statically. One operation is in flight at a time.

---
 rtl/div_uint16_uint8.sv | 150 +++++++++++++++
 tb/tb_div_uint16_uint8.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/div_uint16_uint8.sv
// ============================================================================
//  Module   : div_uint16_uint8
//  Purpose  : Fixed-latency restoring divider (DIVIDEND_W / DIVISOR_W), one op in flight.
//             Optional macro DIV_ZERO_ERR_EN saturates Q/R and raises err on divisor 0.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module div_uint16_uint8 #(
    parameter int DIVIDEND_W = 16,
    parameter int DIVISOR_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] I0,
    input  logic [DIVISOR_W-1:0]  I1,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] Q,
    output logic [DIVISOR_W-1:0]  R,
    output logic                  err
);

    localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DIVIDEND_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DIVISOR_W:0]    rem_q,   rem_d;
    logic [DIVIDEND_W-1:0] quo_q,   quo_d;
    logic [DIVISOR_W-1:0]  dvs_q,   dvs_d;
    logic [CNT_W-1:0]      cnt_q,   cnt_d;
    logic [DIVIDEND_W-1:0] q_q,     q_d;
    logic [DIVISOR_W-1:0]  r_q,     r_d;
    logic                  busy_q,  busy_d;
    logic                  done_q,  done_d;
    logic                  err_q,   err_d;

    logic [DIVISOR_W:0]    rem_sh;
    logic [DIVISOR_W+1:0]  trial;
    logic [DIVISOR_W:0]    rem_nxt;
    logic [DIVIDEND_W-1:0] quo_nxt;

    // One restoring step; the extra top bit of trial is the borrow.
    always_comb begin
        rem_sh = {rem_q[DIVISOR_W-1:0], quo_q[DIVIDEND_W-1]};
        trial  = {1'b0, rem_sh} - {2'b00, dvs_q};
        if (!trial[DIVISOR_W+1]) begin
            rem_nxt = trial[DIVISOR_W:0];
            quo_nxt = {quo_q[DIVIDEND_W-2:0], 1'b1};
        end else begin
            rem_nxt = rem_sh;
            quo_nxt = {quo_q[DIVIDEND_W-2:0], 1'b0};
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        r_d     = r_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    dvs_d   = I1;
                    rem_d   = '0;
                    quo_d   = I0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_CALC;
                end else begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                rem_d = rem_nxt;
                quo_d = quo_nxt;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == C_LAST) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    q_d     = quo_nxt;
                    r_d     = rem_nxt[DIVISOR_W-1:0];
                    err_d   = 1'b0;
`ifdef DIV_ZERO_ERR_EN
                    if (dvs_q == '0) begin
                        q_d   = '1;
                        r_d   = '1;
                        err_d = 1'b1;
                    end
`else
`endif
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            r_q     <= r_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign Q    = q_q;
    assign R    = r_q;
    assign err  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_div_uint16_uint8.sv
// ============================================================================
//  Module   : tb_div_uint16_uint8
//  Purpose  : Self-checking bench for div_uint16_uint8 against an arithmetic model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_div_uint16_uint8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] I0;
    logic [7:0]  I1;
    logic        busy;
    logic        done;
    logic [15:0] Q;
    logic [7:0]  R;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    div_uint16_uint8 #(.DIVIDEND_W(16), .DIVISOR_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .I0    (I0),
        .I1    (I1),
        .busy  (busy),
        .done  (done),
        .Q     (Q),
        .R     (R),
        .err   (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division with the divide-by-zero rule applied.
    task automatic model(input logic [15:0] a, input logic [7:0] b,
                         output logic [15:0] q, output logic [7:0] r, output logic e);
        if (b == 8'd0) begin
            q = 16'hFFFF;
`ifdef DIV_ZERO_ERR_EN
            r = 8'hFF;
            e = 1'b1;
`else
            r = a[7:0];
            e = 1'b0;
`endif
        end else begin
            q = a / {8'd0, b};
            r = 8'(a % {8'd0, b});
            e = 1'b0;
        end
    endtask

    task automatic check_res(input string tag, input logic [15:0] a, input logic [7:0] b);
        logic [15:0] eq;
        logic [7:0]  er;
        logic        ee;
        model(a, b, eq, er, ee);
        check({tag, ".q"},   32'(Q),   32'(eq));
        check({tag, ".r"},   32'(R),   32'(er));
        check({tag, ".err"}, 32'(err), 32'(ee));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int lat);
        I0 = a; I1 = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        wait_done(lat);
    endtask

    initial begin
        int lat;
        int pulses;
        logic [15:0] a;
        logic [7:0]  b;

        rst_n = 1'b0; start = 1'b0; I0 = '0; I1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.q",    32'(Q),    32'd0);
        check("rst.r",    32'(R),    32'd0);
        check("rst.err",  32'(err),  32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("idle.outs", {13'd0, busy, done, err, Q}, 32'd0);
            check("idle.r", 32'(R), 32'd0);
        end

        run_op(16'd1000, 8'd7, lat);
        check("basic.lat", 32'(lat), 32'd16);
        check_res("basic", 16'd1000, 8'd7);
        @(posedge clk); #1;
        check("done_pulse_fall", 32'(done), 32'd0);
        check("hold.q", 32'(Q), 32'd142);

        // Back-to-back: start held high across the whole first op.
        I0 = 16'd65535; I1 = 8'd255; start = 1'b1;
        @(posedge clk); #1;
        I0 = 16'd5; I1 = 8'd9;
        wait_done(lat);
        check("b2b1.lat", 32'(lat), 32'd16);
        check_res("b2b1", 16'd65535, 8'd255);
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b.busy", 32'(busy), 32'd1);
        check("b2b.q_hold", 32'(Q), 32'd257);
        wait_done(lat);
        check("b2b2.gap", 32'(lat + 1), 32'd17);
        check_res("b2b2", 16'd5, 8'd9);

        run_op(16'h1234, 8'd0, lat);
        check("dz.lat", 32'(lat), 32'd16);
        check_res("dz", 16'h1234, 8'd0);

        // Start pulse mid-run must be ignored.
        I0 = 16'd1000; I1 = 8'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 5) begin start = 1'b1; I0 = 16'd9; I1 = 8'd2; end
            if (lat == 6) start = 1'b0;
        end
        check("ign.lat", 32'(lat), 32'd16);
        check_res("ign", 16'd1000, 8'd7);
        @(posedge clk); #1;
        check("ign.no_restart", {30'd0, busy, done}, 32'd0);

        // Asynchronous reset in the middle of CALC.
        I0 = 16'd50000; I1 = 8'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("abort.busy", 32'(busy), 32'd0);
        check("abort.q",    32'(Q),    32'd0);
        check("abort.r",    32'(R),    32'd0);
        check("abort.err",  32'(err),  32'd0);
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        check("abort.no_done", 32'(pulses), 32'd0);
        check("abort.q_idle", 32'(Q), 32'd0);
        run_op(16'd200, 8'd3, lat);
        check("post_rst.lat", 32'(lat), 32'd16);
        check_res("post_rst", 16'd200, 8'd3);

        for (int i = 0; i < 40; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
            if (i % 4 == 3) a = 16'($urandom_range(0, 300));
            run_op(a, b, lat);
            check("rnd.lat", 32'(lat), 32'd16);
            check_res("rnd", a, b);
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
